// File: rtl/mos6502_pkg.sv
// Shared constants for the 6502 instruction register / T-state sequencer.
package mos6502_pkg;

  localparam int TS_T0  = 0;
  localparam int TS_T1X = 1;
  localparam int TS_T2  = 2;
  localparam int TS_T3  = 3;
  localparam int TS_T4  = 4;
  localparam int TS_T5  = 5;
  localparam int TS_W   = 6;

  localparam logic [TS_W-1:0] TS_T0_OH  = 6'b000001;
  localparam logic [TS_W-1:0] TS_T1X_OH = 6'b000010;
  localparam logic [TS_W-1:0] TS_T5_OH  = 6'b100000;

  localparam logic [7:0] OP_BRK = 8'h00;

endpackage

// File: rtl/tstate_ring.sv
// One-hot T-state ring: T0 -> T1X -> T2..T5 (saturating), ENDS returns to T0.
module tstate_ring
  import mos6502_pkg::*;
(
  input  logic            clk,
  input  logic            res,
  input  logic            rdy,
  input  logic            end_req,
  output logic [TS_W-1:0] ts
);

  logic [TS_W-1:0] ts_next;

  always_ff @(posedge clk) begin
    if (res) ts <= TS_T0_OH;
    else     ts <= ts_next;
  end

  always_comb begin
    ts_next = ts;
    if (rdy) begin
      if (ts[TS_T0])      ts_next = TS_T1X_OH;
      else if (end_req)   ts_next = TS_T0_OH;
      else if (ts[TS_T5]) ts_next = TS_T5_OH;
      else                ts_next = {ts[TS_W-2:0], 1'b0};
    end
    // An upset that clears the ring must not strand the sequencer.
    if (ts_next == '0) ts_next = TS_T0_OH;
  end

endmodule

// File: rtl/ir_tstate_gen.sv
// Instruction register + T-state sequencer feeding the 6502 decoder.
// Optional build macro TGEN_BRK_INJECT_EN: a pending interrupt forces BRK into IR at T0->T1X.
module ir_tstate_gen
  import mos6502_pkg::*;
#(
  parameter logic [7:0] IR_RESET = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             RDY,
  input  logic             ENDS,
  input  logic [7:0]       PD,
  input  logic             INT_PEND,
  output logic [7:0]       IR,
  output logic [7:0]       n_IR,
  output logic             IR01,
  output logic             n_T0,
  output logic             n_T1X,
  output logic             n_T2,
  output logic             n_T3,
  output logic             n_T4,
  output logic             n_T5,
  output logic [CNT_W-1:0] ICNT
);

  logic [TS_W-1:0] ts;
  logic            load;
  logic [7:0]      ir_d;

  tstate_ring u_ring (
    .clk     (CLK),
    .res     (RES),
    .rdy     (RDY),
    .end_req (ENDS),
    .ts      (ts)
  );

  assign load = RDY & ts[TS_T0];

`ifdef TGEN_BRK_INJECT_EN
  assign ir_d = INT_PEND ? OP_BRK : PD;
`else
  logic unused_int_pend;
  assign unused_int_pend = INT_PEND;
  assign ir_d = PD;
`endif

  // IR/n_IR/IR01 are all flopped so the decoder sees no input-to-output path.
  always_ff @(posedge CLK) begin
    if (RES) begin
      IR   <= IR_RESET;
      n_IR <= ~IR_RESET;
      IR01 <= |IR_RESET[1:0];
      ICNT <= '0;
    end else if (load) begin
      IR   <= ir_d;
      n_IR <= ~ir_d;
      IR01 <= |ir_d[1:0];
      ICNT <= ICNT + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign n_T0  = ~ts[TS_T0];
  assign n_T1X = ~ts[TS_T1X];
  assign n_T2  = ~ts[TS_T2];
  assign n_T3  = ~ts[TS_T3];
  assign n_T4  = ~ts[TS_T4];
  assign n_T5  = ~ts[TS_T5];

endmodule

// File: tb/tb_ir_tstate_gen.sv
// Directed self-checking bench for ir_tstate_gen (default parameters).
module tb_ir_tstate_gen;

  logic        CLK = 1'b0;
  logic        RES, RDY, ENDS, INT_PEND;
  logic [7:0]  PD;
  logic [7:0]  IR, n_IR;
  logic        IR01;
  logic        n_T0, n_T1X, n_T2, n_T3, n_T4, n_T5;
  logic [15:0] ICNT;
  logic [5:0]  nt;

  int checks = 0;
  int errors = 0;

  // {n_T5..n_T0} for each state
  localparam logic [5:0] S_T0 = 6'b111110;
  localparam logic [5:0] S_T1 = 6'b111101;
  localparam logic [5:0] S_T2 = 6'b111011;
  localparam logic [5:0] S_T3 = 6'b110111;
  localparam logic [5:0] S_T4 = 6'b101111;
  localparam logic [5:0] S_T5 = 6'b011111;

  logic [5:0] sat_seq [8];

  ir_tstate_gen #(.IR_RESET(8'h00), .CNT_W(16)) dut (
    .CLK(CLK), .RES(RES), .RDY(RDY), .ENDS(ENDS), .PD(PD), .INT_PEND(INT_PEND),
    .IR(IR), .n_IR(n_IR), .IR01(IR01),
    .n_T0(n_T0), .n_T1X(n_T1X), .n_T2(n_T2), .n_T3(n_T3), .n_T4(n_T4), .n_T5(n_T5),
    .ICNT(ICNT)
  );

  always #5 CLK = ~CLK;
  assign nt = {n_T5, n_T4, n_T3, n_T2, n_T1X, n_T0};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RES = 1'b1; RDY = 1'b1; ENDS = 1'b0; PD = 8'h00; INT_PEND = 1'b0;
    tick(); tick();
    RES = 1'b0;
    checks++; if (nt !== S_T0) begin errors++; $display("FAIL reset_state got=%b exp=%b", nt, S_T0); end
    checks++; if (IR !== 8'h00) begin errors++; $display("FAIL reset_ir got=%h exp=00", IR); end
    checks++; if (n_IR !== 8'hFF) begin errors++; $display("FAIL reset_n_ir got=%h exp=ff", n_IR); end
    checks++; if (IR01 !== 1'b0) begin errors++; $display("FAIL reset_ir01 got=%b exp=0", IR01); end
    checks++; if (ICNT !== 16'd0) begin errors++; $display("FAIL reset_icnt got=%0d exp=0", ICNT); end
  endtask

  task automatic test_two_cycle();
    PD = 8'hA9; ENDS = 1'b1;  // ENDS ignored in T0
    tick();
    PD = 8'h55;
    checks++; if (nt !== S_T1) begin errors++; $display("FAIL two_cycle_t1 got=%b exp=%b", nt, S_T1); end
    checks++; if (IR !== 8'hA9) begin errors++; $display("FAIL two_cycle_ir got=%h exp=a9", IR); end
    checks++; if (n_IR !== 8'h56) begin errors++; $display("FAIL two_cycle_n_ir got=%h exp=56", n_IR); end
    checks++; if (IR01 !== 1'b1) begin errors++; $display("FAIL two_cycle_ir01 got=%b exp=1", IR01); end
    tick();
    checks++; if (nt !== S_T0) begin errors++; $display("FAIL two_cycle_t0 got=%b exp=%b", nt, S_T0); end
    checks++; if (ICNT !== 16'd1) begin errors++; $display("FAIL two_cycle_icnt got=%0d exp=1", ICNT); end
    checks++; if (IR !== 8'hA9) begin errors++; $display("FAIL two_cycle_ir_hold got=%h exp=a9", IR); end
  endtask

  task automatic test_saturate();
    PD = 8'h6C; ENDS = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      PD = PD ^ 8'hFF;
      checks++; if (nt !== sat_seq[i]) begin errors++; $display("FAIL saturate_state[%0d] got=%b exp=%b", i, nt, sat_seq[i]); end
      checks++; if (IR !== 8'h6C) begin errors++; $display("FAIL saturate_ir[%0d] got=%h exp=6c", i, IR); end
    end
    checks++; if (ICNT !== 16'd2) begin errors++; $display("FAIL saturate_icnt got=%0d exp=2", ICNT); end
  endtask

  task automatic test_stall();
    ENDS = 1'b1; tick();           // T5 -> T0
    ENDS = 1'b0; PD = 8'h11; tick(); // T1X, IR=11, ICNT=3
    PD = 8'h22; tick(); tick();    // T2, T3
    checks++; if (nt !== S_T3) begin errors++; $display("FAIL stall_pre got=%b exp=%b", nt, S_T3); end
    RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PD = 8'h33 + 8'(i); ENDS = i[0];
      tick();
      checks++; if (nt !== S_T3) begin errors++; $display("FAIL stall_state[%0d] got=%b exp=%b", i, nt, S_T3); end
      checks++; if (IR !== 8'h11) begin errors++; $display("FAIL stall_ir[%0d] got=%h exp=11", i, IR); end
      checks++; if (ICNT !== 16'd3) begin errors++; $display("FAIL stall_icnt[%0d] got=%0d exp=3", i, ICNT); end
    end
    RDY = 1'b1; ENDS = 1'b0;
    tick();
    checks++; if (nt !== S_T4) begin errors++; $display("FAIL stall_resume got=%b exp=%b", nt, S_T4); end
  endtask

  task automatic test_reset_mid();
    RDY = 1'b0; RES = 1'b1; PD = 8'h77;
    tick();
    RES = 1'b0; RDY = 1'b1;
    checks++; if (nt !== S_T0) begin errors++; $display("FAIL reset_mid_state got=%b exp=%b", nt, S_T0); end
    checks++; if (IR !== 8'h00) begin errors++; $display("FAIL reset_mid_ir got=%h exp=00", IR); end
    checks++; if (n_IR !== 8'hFF) begin errors++; $display("FAIL reset_mid_n_ir got=%h exp=ff", n_IR); end
    checks++; if (ICNT !== 16'd0) begin errors++; $display("FAIL reset_mid_icnt got=%0d exp=0", ICNT); end
  endtask

  task automatic test_brk_inject();
    logic [7:0] exp_ir;
`ifdef TGEN_BRK_INJECT_EN
    exp_ir = 8'h00;
`else
    exp_ir = 8'hEA;
`endif
    PD = 8'hEA; INT_PEND = 1'b1; ENDS = 1'b0;
    tick();
    INT_PEND = 1'b0;
    checks++; if (nt !== S_T1) begin errors++; $display("FAIL brk_state got=%b exp=%b", nt, S_T1); end
    checks++; if (IR !== exp_ir) begin errors++; $display("FAIL brk_ir got=%h exp=%h", IR, exp_ir); end
    checks++; if (n_IR !== ~exp_ir) begin errors++; $display("FAIL brk_n_ir got=%h exp=%h", n_IR, ~exp_ir); end
    checks++; if (IR01 !== |exp_ir[1:0]) begin errors++; $display("FAIL brk_ir01 got=%b exp=%b", IR01, |exp_ir[1:0]); end
    checks++; if (ICNT !== 16'd1) begin errors++; $display("FAIL brk_icnt got=%0d exp=1", ICNT); end
  endtask

  task automatic test_back_to_back();
    tick();                          // T1X -> T2
    checks++; if (nt !== S_T2) begin errors++; $display("FAIL b2b_t2 got=%b exp=%b", nt, S_T2); end
    ENDS = 1'b1; tick();             // T2 -> T0
    checks++; if (nt !== S_T0) begin errors++; $display("FAIL b2b_t0 got=%b exp=%b", nt, S_T0); end
    ENDS = 1'b0; PD = 8'h03; tick(); // T0 -> T1X
    checks++; if (nt !== S_T1) begin errors++; $display("FAIL b2b_t1 got=%b exp=%b", nt, S_T1); end
    checks++; if (IR !== 8'h03) begin errors++; $display("FAIL b2b_ir got=%h exp=03", IR); end
    checks++; if (n_IR !== 8'hFC) begin errors++; $display("FAIL b2b_n_ir got=%h exp=fc", n_IR); end
    checks++; if (IR01 !== 1'b1) begin errors++; $display("FAIL b2b_ir01 got=%b exp=1", IR01); end
    checks++; if (ICNT !== 16'd2) begin errors++; $display("FAIL b2b_icnt got=%0d exp=2", ICNT); end
    ENDS = 1'b1; PD = 8'h04; tick(); // T1X -> T0
    ENDS = 1'b0; tick();             // T0 -> T1X, IR=04, IR01=0
    checks++; if (IR01 !== 1'b0) begin errors++; $display("FAIL b2b_ir01_zero got=%b exp=0", IR01); end
    checks++; if (ICNT !== 16'd3) begin errors++; $display("FAIL b2b_icnt2 got=%0d exp=3", ICNT); end
  endtask

  initial begin
    sat_seq = '{S_T1, S_T2, S_T3, S_T4, S_T5, S_T5, S_T5, S_T5};
    test_reset();
    test_two_cycle();
    test_saturate();
    test_stall();
    test_reset_mid();
    test_brk_inject();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
